regfile_wb_arbiter: RTL and testbench

Write-back controller for the 32x32 register file. It shares the file's single write port (RegWrite/WriteReg/WriteData) between two producers: A is the ALU and B is the load unit. Arbitration is round-robin over valid/ready handshakes. It also keeps a per-register pending scoreboard that gates instruction issue on RAW and WAW hazards.

---
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the 32x32 register file: round-robin arbitration of
// the ALU (A) and load unit (B) onto the single write port, plus a pending scoreboard.
module regfile_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [AW-1:0]     a_reg,
    input  logic [DW-1:0]     a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [AW-1:0]     b_reg,
    input  logic [DW-1:0]     b_data,
    output logic              b_ready,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rs1,
    input  logic [AW-1:0]     iss_rs2,
    input  logic [AW-1:0]     iss_rd,
    input  logic              iss_wr,
    output logic              iss_accept,
    output logic [2**AW-1:0]  busy,
    output logic              RegWrite,
    output logic [AW-1:0]     WriteReg,
    output logic [DW-1:0]     WriteData
);

    localparam int NR = 2**AW;

    logic          grantA;
    logic          grantB;
    logic          xfer;
    logic [AW-1:0] grantReg;
    logic [DW-1:0] grantData;
    logic          hazard;

    logic          prio_q, prio_d;
    logic          regWrite_q, regWrite_d;
    logic [AW-1:0] writeReg_q, writeReg_d;
    logic [DW-1:0] writeData_q, writeData_d;
    logic [NR-1:0] busy_q, busy_d;

    // prio_q=1 means B wins the next contended cycle
    always_comb begin
        grantA    = a_valid & (~b_valid | ~prio_q);
        grantB    = b_valid & (~a_valid |  prio_q);
        xfer      = grantA | grantB;
        grantReg  = grantA ? a_reg  : b_reg;
        grantData = grantA ? a_data : b_data;
    end

    always_comb begin
        prio_d      = prio_q;
        regWrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        if (xfer) begin
            prio_d      = grantA;
            regWrite_d  = (grantReg != '0);
            writeReg_d  = grantReg;
            writeData_d = grantData;
        end
    end

    // Clear is applied before set so that a same-register collision leaves it pending
    always_comb begin
        hazard     = busy_q[iss_rs1] | busy_q[iss_rs2] | (iss_wr & busy_q[iss_rd]);
        iss_accept = iss_valid & ~hazard;
        busy_d     = busy_q;
        if (xfer) begin
            busy_d[grantReg] = 1'b0;
        end
        if (iss_accept && iss_wr && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q      <= 1'b0;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
            busy_q      <= '0;
        end else begin
            prio_q      <= prio_d;
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
            busy_q      <= busy_d;
        end
    end

    assign a_ready   = grantA;
    assign b_ready   = grantB;
    assign busy      = busy_q;
    assign RegWrite  = regWrite_q;
    assign WriteReg  = writeReg_q;
    assign WriteData = writeData_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, reset-mid-write
// sequence, then randomized traffic against a transaction-level reference model.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        a_valid, b_valid, iss_valid, iss_wr;
    logic [4:0]  a_reg, b_reg, iss_rs1, iss_rs2, iss_rd;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, iss_accept;
    logic [31:0] busy;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;

    int checks = 0;
    int passes = 0;

    regfile_wb_arbiter #(.DW(32), .AW(5)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_wr(iss_wr), .iss_accept(iss_accept), .busy(busy),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic av; logic [4:0] ar; logic [31:0] ad;
        logic bv; logic [4:0] br; logic [31:0] bd;
        logic iv; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd; logic wr;
        logic expA; logic expB; logic expAcc;
        logic expRw; logic [4:0] expWr; logic [31:0] expWd; logic [31:0] expBusy;
    } vec_t;

    vec_t vecs[$];

    // Reference model: write port modelled as "who wins, what gets written"
    bit          mPrioB;
    bit          mBusy[32];
    bit          mRw;
    logic [4:0]  mWr;
    logic [31:0] mWd;
    bit          holdA, holdB;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        else
            passes++;
    endtask

    task automatic driveAll(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                            input logic bv, input logic [4:0] br, input logic [31:0] bd,
                            input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic wr);
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        iss_valid = iv; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_wr = wr;
    endtask

    task automatic doReset();
        driveAll(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        mPrioB = 0; mRw = 0; mWr = 0; mWd = 0; holdA = 0; holdB = 0;
        for (int i = 0; i < 32; i++) mBusy[i] = 0;
    endtask

    function automatic logic [31:0] modelBusy();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mBusy[i];
        return v;
    endfunction

    // 0 = nobody, 1 = ALU, 2 = load unit
    function automatic int modelWinner();
        if (a_valid && b_valid) return mPrioB ? 2 : 1;
        if (a_valid) return 1;
        if (b_valid) return 2;
        return 0;
    endfunction

    function automatic bit modelAccept();
        int s1, s2, d;
        s1 = int'(iss_rs1); s2 = int'(iss_rs2); d = int'(iss_rd);
        return iss_valid && !(mBusy[s1] || mBusy[s2] || (iss_wr && mBusy[d]));
    endfunction

    task automatic applyStimulus();
        if (!holdA) begin
            a_valid = ($urandom_range(0, 1) == 1);
            a_reg   = 5'($urandom_range(0, 7));
            a_data  = $urandom;
        end
        if (!holdB) begin
            b_valid = ($urandom_range(0, 1) == 1);
            b_reg   = 5'($urandom_range(0, 7));
            b_data  = $urandom;
        end
        iss_valid = ($urandom_range(0, 9) < 7);
        iss_rs1   = 5'($urandom_range(0, 7));
        iss_rs2   = 5'($urandom_range(0, 7));
        iss_rd    = 5'($urandom_range(0, 7));
        iss_wr    = ($urandom_range(0, 9) < 7);
    endtask

    task automatic checkOutput();
        int w;
        w = modelWinner();
        check("rnd_a_ready", 64'(a_ready), 64'(w == 1));
        check("rnd_b_ready", 64'(b_ready), 64'(w == 2));
        check("rnd_iss_accept", 64'(iss_accept), 64'(modelAccept()));
        check("rnd_busy", 64'(busy), 64'(modelBusy()));
        check("rnd_RegWrite", 64'(RegWrite), 64'(mRw));
        check("rnd_WriteReg", 64'(WriteReg), 64'(mWr));
        check("rnd_WriteData", 64'(WriteData), 64'(mWd));
    endtask

    task automatic modelEdge();
        int w;
        bit acc;
        logic [4:0] r;
        w   = modelWinner();
        acc = modelAccept();
        if (w != 0) begin
            r      = (w == 1) ? a_reg : b_reg;
            mWr    = r;
            mWd    = (w == 1) ? a_data : b_data;
            mRw    = (r != 0);
            mPrioB = (w == 1);
            mBusy[int'(r)] = 0;
        end else begin
            mRw = 0;
        end
        if (acc && iss_wr && iss_rd != 0) mBusy[int'(iss_rd)] = 1;
        holdA = a_valid && (w != 1);
        holdB = b_valid && (w != 2);
    endtask

    initial begin
        reset = 1'b1;
        driveAll(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset_RegWrite", 64'(RegWrite), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        doReset();
        check("reset_WriteReg", 64'(WriteReg), 64'd0);
        check("reset_WriteData", 64'(WriteData), 64'd0);

        // av ar ad | bv br bd | iv rs1 rs2 rd wr | expA expB expAcc | expRw expWr expWd expBusy
        vecs.push_back('{1, 3, 32'h11,   1, 4, 32'h22,   0, 0, 0, 0, 0,  1, 0, 0,  1, 3, 32'h11,   32'h0});
        vecs.push_back('{1, 3, 32'h11,   1, 4, 32'h22,   0, 0, 0, 0, 0,  0, 1, 0,  1, 4, 32'h22,   32'h0});
        vecs.push_back('{1, 3, 32'h11,   1, 4, 32'h22,   0, 0, 0, 0, 0,  1, 0, 0,  1, 3, 32'h11,   32'h0});
        vecs.push_back('{1, 3, 32'h11,   1, 4, 32'h22,   0, 0, 0, 0, 0,  0, 1, 0,  1, 4, 32'h22,   32'h0});
        vecs.push_back('{0, 0, 32'h0,    1, 0, 32'hDEAD, 0, 0, 0, 0, 0,  0, 1, 0,  0, 0, 32'hDEAD, 32'h0});
        vecs.push_back('{0, 0, 32'h0,    0, 0, 32'h0,    1, 1, 2, 7, 1,  0, 0, 1,  0, 0, 32'hDEAD, 32'h80});
        vecs.push_back('{0, 0, 32'h0,    0, 0, 32'h0,    1, 7, 0, 8, 1,  0, 0, 0,  0, 0, 32'hDEAD, 32'h80});
        vecs.push_back('{1, 7, 32'h77,   0, 0, 32'h0,    1, 7, 0, 8, 1,  1, 0, 0,  1, 7, 32'h77,   32'h0});
        vecs.push_back('{0, 0, 32'h0,    0, 0, 32'h0,    1, 7, 0, 8, 1,  0, 0, 1,  0, 7, 32'h77,   32'h100});
        vecs.push_back('{0, 0, 32'h0,    0, 0, 32'h0,    1, 0, 0, 8, 1,  0, 0, 0,  0, 7, 32'h77,   32'h100});
        vecs.push_back('{0, 0, 32'h0,    1, 9, 32'h99,   1, 0, 0, 9, 1,  0, 1, 1,  1, 9, 32'h99,   32'h300});
        vecs.push_back('{1, 8, 32'h88,   1, 9, 32'h98,   1, 9, 0,10, 1,  1, 0, 0,  1, 8, 32'h88,   32'h200});
        vecs.push_back('{1, 2, 32'hCAFE, 0, 0, 32'h0,    0, 0, 0, 0, 0,  1, 0, 0,  1, 2, 32'hCAFE, 32'h200});
        vecs.push_back('{0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 0,  0, 0, 0,  0, 2, 32'hCAFE, 32'h200});
        vecs.push_back('{0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 0,  0, 0, 0,  0, 2, 32'hCAFE, 32'h200});
        vecs.push_back('{0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 0,  0, 0, 0,  0, 2, 32'hCAFE, 32'h200});
        vecs.push_back('{1, 3, 32'h33,   1, 4, 32'h44,   0, 0, 0, 0, 0,  0, 1, 0,  1, 4, 32'h44,   32'h200});
        vecs.push_back('{0, 0, 32'h0,    0, 0, 32'h0,    1, 1, 2, 9, 0,  0, 0, 1,  0, 4, 32'h44,   32'h200});
        vecs.push_back('{0, 0, 32'h0,    0, 0, 32'h0,    1, 0, 0, 0, 1,  0, 0, 1,  0, 4, 32'h44,   32'h200});
        vecs.push_back('{0, 0, 32'h0,    0, 0, 32'h0,    1, 0, 9, 0, 0,  0, 0, 0,  0, 4, 32'h44,   32'h200});
        vecs.push_back('{0, 0, 32'h0,    1, 9, 32'h5,    1, 0, 0,10, 1,  0, 1, 1,  1, 9, 32'h5,    32'h400});

        foreach (vecs[i]) begin
            driveAll(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd,
                     vecs[i].iv, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wr);
            @(negedge clk);
            check($sformatf("vec%0d_a_ready", i), 64'(a_ready), 64'(vecs[i].expA));
            check($sformatf("vec%0d_b_ready", i), 64'(b_ready), 64'(vecs[i].expB));
            check($sformatf("vec%0d_iss_accept", i), 64'(iss_accept), 64'(vecs[i].expAcc));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_RegWrite", i), 64'(RegWrite), 64'(vecs[i].expRw));
            check($sformatf("vec%0d_WriteReg", i), 64'(WriteReg), 64'(vecs[i].expWr));
            check($sformatf("vec%0d_WriteData", i), 64'(WriteData), 64'(vecs[i].expWd));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].expBusy));
        end

        // Reset lands while a grant is pending: nothing may be written until after release
        driveAll(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_pre_a_ready", 64'(a_ready), 64'd1);
        reset = 1'b1;
        #1;
        check("rst_async_RegWrite", 64'(RegWrite), 64'd0);
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_WriteData", 64'(WriteData), 64'd0);
        @(posedge clk);
        #1;
        check("rst_held_RegWrite", 64'(RegWrite), 64'd0);
        check("rst_held_WriteReg", 64'(WriteReg), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_post_a_ready", 64'(a_ready), 64'd1);
        @(posedge clk);
        #1;
        check("rst_xfer_RegWrite", 64'(RegWrite), 64'd1);
        check("rst_xfer_WriteReg", 64'(WriteReg), 64'd5);
        check("rst_xfer_WriteData", 64'(WriteData), 64'h1234);
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_after_RegWrite", 64'(RegWrite), 64'd0);

        doReset();
        for (int n = 0; n < 600; n++) begin
            applyStimulus();
            @(negedge clk);
            checkOutput();
            @(posedge clk);
            modelEdge();
            #1;
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
